// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC direction codes, flit field offsets and route helper
package noc_pkg;

  localparam logic [2:0] DIR_R  = 3'd0;
  localparam logic [2:0] DIR_L  = 3'd1;
  localparam logic [2:0] DIR_U  = 3'd2;
  localparam logic [2:0] DIR_D  = 3'd3;
  localparam logic [2:0] DIR_EJ = 3'd4;

  // Coordinate fields sit at the top of the flit: X in the top three bits,
  // Y directly below. Offsets are measured down from DATA_W.
  localparam int COORD_W = 3;
  localparam int X_TOP   = 1;
  localparam int Y_TOP   = 4;

  // XY dimension-order routing: resolve X first, then Y, else eject here.
  function automatic logic [2:0] route_code(input logic [2:0] dest_x,
                                            input logic [2:0] dest_y,
                                            input logic [2:0] my_x,
                                            input logic [2:0] my_y);
    if (dest_x > my_x)      return DIR_R;
    else if (dest_x < my_x) return DIR_L;
    else if (dest_y > my_y) return DIR_U;
    else if (dest_y < my_y) return DIR_D;
    else                    return DIR_EJ;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];

  // Storage array: written on push only, never reset (stale data is unreachable).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_buffer_rc.sv
// rtl/input_buffer_rc.sv - router input buffer with enqueue-time route compute and grant blanking
module input_buffer_rc
  import noc_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter int         DEPTH  = 4,
  parameter logic [2:0] MY_X   = 3'd0,
  parameter logic [2:0] MY_Y   = 3'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       req,
  output logic [2:0]                 dir,
  input  logic                       grant,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);

  logic [2:0]        route;
  logic [DATA_W+2:0] head;
  logic              empty;
  logic              push;
  logic              pop;
  logic              bad_grant;
  logic              blank;

  assign route = route_code(in_data[DATA_W-X_TOP -: COORD_W],
                            in_data[DATA_W-Y_TOP -: COORD_W], MY_X, MY_Y);

  assign empty     = (count == '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  // The grant arriving in the blanked cycle answers a req we already served.
  assign pop       = grant && !empty && !blank;
  assign bad_grant = grant && (empty || blank);

  assign req      = !empty && !blank;
  assign out_data = empty ? '0 : head[DATA_W+2:3];
  assign dir      = empty ? '0 : head[2:0];

  sync_fifo #(
    .WIDTH (DATA_W + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({in_data, route}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  // Blank req for one cycle after each pop; latch any stray grant as a sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank <= 1'b0;
      err   <= 1'b0;
    end else begin
      blank <= pop;
      if (bad_grant) err <= 1'b1;
    end
  end

endmodule
